// File: rtl/clk_div.sv
// Free-running binary divider plus a registered square-wave tick of period 1/TICK_HZ.
// Both outputs come straight from flops; reset clears everything asynchronously.
module clk_div #(
  parameter int unsigned CLK_FREQ_HZ = 32'd100_000_000,
  parameter int unsigned TICK_HZ     = 32'd1000,
  parameter int unsigned DIV_WIDTH   = 32'd32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [DIV_WIDTH-1:0] div,
  output logic                 clk_1ms
);

  localparam int unsigned HALF  = CLK_FREQ_HZ / (32'd2 * TICK_HZ);
  // A one-cycle half period still needs a 1-bit counter that is always at its terminal value.
  localparam int unsigned CNT_W = (HALF > 32'd1) ? $clog2(HALF) : 32'd1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 32'd1);

  generate
    if (HALF < 32'd1) begin : g_half_check
      $error("clk_div: TICK_HZ too high for CLK_FREQ_HZ, half period is zero cycles");
    end
  endgenerate

  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] div_s;
  logic [CNT_W-1:0]     ms_cnt_r;
  logic [CNT_W-1:0]     ms_cnt_s;
  logic                 clk_1ms_r;
  logic                 clk_1ms_s;
  logic                 half_done_s;

  // Next-state: divider wraps naturally; tick counter reloads and toggles at its terminal count.
  always_comb begin
    div_s       = div_r + DIV_WIDTH'(1'b1);
    ms_cnt_s    = ms_cnt_r;
    clk_1ms_s   = clk_1ms_r;
    half_done_s = (ms_cnt_r == HALF_M1);
    if (half_done_s) begin
      ms_cnt_s  = '0;
      clk_1ms_s = ~clk_1ms_r;
    end else begin
      ms_cnt_s  = ms_cnt_r + CNT_W'(1'b1);
      clk_1ms_s = clk_1ms_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r     <= '0;
      ms_cnt_r  <= '0;
      clk_1ms_r <= 1'b0;
    end else begin
      div_r     <= div_s;
      ms_cnt_r  <= ms_cnt_s;
      clk_1ms_r <= clk_1ms_s;
    end
  end

  assign div     = div_r;
  assign clk_1ms = clk_1ms_r;

endmodule

// File: tb/tb_clk_div.sv
// Directed bench for clk_div: a HALF=5 / 4-bit instance and a HALF=1 / 8-bit instance,
// checked against an edge-count model through a scoreboard queue.
module tb_clk_div;

  logic       clk;
  logic       rst_n;
  logic [3:0] div_a;
  logic       tick_a;
  logic [7:0] div_b;
  logic       tick_b;

  typedef struct packed {
    logic [3:0] div_a;
    logic       tick_a;
    logic [7:0] div_b;
    logic       tick_b;
  } exp_t;

  exp_t q[$];
  int   n;
  int   tests;
  int   fails;

  clk_div #(.CLK_FREQ_HZ(32'd1000), .TICK_HZ(32'd100), .DIV_WIDTH(32'd4)) dut_a (
    .clk(clk), .rst_n(rst_n), .div(div_a), .clk_1ms(tick_a)
  );

  clk_div #(.CLK_FREQ_HZ(32'd2), .TICK_HZ(32'd1), .DIV_WIDTH(32'd8)) dut_b (
    .clk(clk), .rst_n(rst_n), .div(div_b), .clk_1ms(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after n edges since release: tick high in odd-numbered blocks of HALF edges.
  task automatic push_exp();
    exp_t e;
    e.div_a  = 4'(n % 16);
    e.tick_a = ((n / 5) % 2) == 1;
    e.div_b  = 8'(n % 256);
    e.tick_b = (n % 2) == 1;
    q.push_back(e);
  endtask

  task automatic check(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = q.pop_front();
      tests++;
      assert (div_a === e.div_a) else begin
        fails++;
        $error("FAIL %s div_a n=%0d observed=%0h expected=%0h", tag, n, div_a, e.div_a);
      end
      tests++;
      assert (tick_a === e.tick_a) else begin
        fails++;
        $error("FAIL %s tick_a n=%0d observed=%b expected=%b", tag, n, tick_a, e.tick_a);
      end
      tests++;
      assert (div_b === e.div_b) else begin
        fails++;
        $error("FAIL %s div_b n=%0d observed=%0h expected=%0h", tag, n, div_b, e.div_b);
      end
      tests++;
      assert (tick_b === e.tick_b) else begin
        fails++;
        $error("FAIL %s tick_b n=%0d observed=%b expected=%b", tag, n, tick_b, e.tick_b);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) n++;
    push_exp();
    #1;
    check(tag);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    tests = 0;
    fails = 0;
    n     = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    push_exp();
    check("reset_immediate");

    for (int i = 0; i < 5; i++) step("reset_hold");

    // Release between edges at t=101; the next posedge is the first count.
    #(101 - $time);
    rst_n = 1'b1;
    for (int i = 0; i < 37; i++) step("run_first");

    // Tick is high here (37 edges in); pulse reset between edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    n = 0;
    #1;
    push_exp();
    check("mid_reset_immediate");
    for (int i = 0; i < 3; i++) step("mid_reset_hold");

    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 300; i++) step("run_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, meaning the clk_1ms output frequency in Hz.
REQ-003 SHALL have parameter DIV_WIDTH, default 32, meaning the width of the div counter output.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port div, output, DIV_WIDTH bits: free-running divider counter; bit k is clk divided by 2^(k+1).
REQ-007 SHALL have port clk_1ms, output, 1 bit: square wave of period 1/TICK_HZ (1 ms at defaults), registered.
REQ-008 SHALL use exactly one clock (clk), with reset asynchronous and active-low (rst_n).

Function
REQ-009 SHALL derive HALF = CLK_FREQ_HZ / (2*TICK_HZ) at elaboration; HALF is 50_000 at defaults.
REQ-010 SHALL increment div by 1 on every rising clk edge while rst_n=1.
REQ-011 SHALL wrap div modulo 2^DIV_WIDTH: all-ones is followed by 0 with no stall or flag.
REQ-012 SHALL keep an internal half-period counter ms_cnt sized ceil(log2(HALF)) bits, range 0..HALF-1.
REQ-013 SHALL increment ms_cnt on each rising edge; when ms_cnt == HALF-1, it SHALL load 0 and clk_1ms SHALL toggle on that same edge.
REQ-014 SHALL produce clk_1ms with 50% duty cycle: high for exactly HALF cycles, then low for exactly HALF cycles.
REQ-015 SHALL make the first clk_1ms rising transition after reset release occur on the HALF-th rising clk edge.
REQ-016 SHALL keep ms_cnt independent of div; div wrap SHALL NOT affect clk_1ms phase.
REQ-017 SHALL drive clk_1ms and div directly from flops, with no combinational path from inputs to outputs.
REQ-018 SHALL reject HALF < 1 (e.g. TICK_HZ > CLK_FREQ_HZ/2) at elaboration as an error, since the frequency is unreachable.
REQ-019 SHALL, when HALF == 1, toggle clk_1ms every cycle (clk/2).

Reset
REQ-020 SHALL, while rst_n=0, force div=0, ms_cnt=0 and clk_1ms=0 immediately, without waiting for a clk edge.
REQ-021 SHALL, on a reset asserted mid-period, discard the partial count; after release, timing restarts per REQ-015.
REQ-022 SHALL take its first increment on the first rising clk edge after rst_n rises (div=1 after that edge).
REQ-023 SHALL hold its outputs at reset values while no clk edges occur and rst_n=0.

Verification
REQ-024 SHALL be verified with reset: rst_n=0 for 100 ns with 10 ns clk, then release -> div=0 and clk_1ms=0 during reset; div=1,2,3 on the following three edges.
REQ-025 SHALL be verified for divide chain: run 1024 edges from reset -> div=1024; div[0] toggles every edge; div[3] period 160 ns.
REQ-026 SHALL be verified for tick at defaults: run 100 MHz from reset -> clk_1ms rises at edge 50_000 (500 us), falls at edge 100_000, and has a 1.000 ms period, stable over 5 periods.
REQ-027 SHALL be verified for short parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (HALF=5) -> clk_1ms = 5 cycles high, 5 low, repeating.
REQ-028 SHALL be verified for async mid-run reset: pulse rst_n low between edges during a clk_1ms high phase -> outputs 0 immediately; first rise again HALF edges after release.
REQ-029 SHALL be verified for wrap: DIV_WIDTH=4, run 16 edges from reset -> div sequence 1..15, then 0; clk_1ms unaffected.
